// File: rtl/sro_pkg.sv
// Shared types and constants for the SRO seed-sweep sequencer:
// FSM state encoding, counter-width helper and the default round limit.
package sro_pkg;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'd0,
        ST_FETCH = 4'd1,
        ST_LATCH = 4'd2,
        ST_DPRST = 4'd3,
        ST_LDINH = 4'd4,
        ST_GAP   = 4'd5,
        ST_START = 4'd6,
        ST_RUN   = 4'd7,
        ST_ACCUM = 4'd8,
        ST_DONE  = 4'd9
    } sro_state_e;

    localparam int ROUND_LIMIT_DEFAULT = 1000;

    // Width needed to count 0..n inclusive.
    function automatic int cnt_width(input int n);
        if (n < 1) begin
            return 1;
        end else begin
            return $clog2(n + 1);
        end
    endfunction

endpackage

// File: rtl/sro_rule_accum.sv
// Per-rule "ended-high" counters: RULES saturating counters with
// synchronous clear, a bit-vector increment enable and an indexed read.
module sro_rule_accum
    import sro_pkg::*;
#(
    parameter int RULES     = 32,
    parameter int LOG_RULES = 5,
    parameter int CNT_W     = 11
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 clr,
    input  logic                 en,
    input  logic [RULES-1:0]     bits,
    input  logic [LOG_RULES-1:0] idx,
    output logic [CNT_W-1:0]     data
);

    logic [CNT_W-1:0] cnt_r [RULES];

    // Counter bank: clear wins over increment; counts stick at all-ones.
    always_ff @(posedge clk) begin
        if (rst || clr) begin
            for (int r = 0; r < RULES; r++) begin
                cnt_r[r] <= {CNT_W{1'b0}};
            end
        end else if (en) begin
            for (int r = 0; r < RULES; r++) begin
                if (bits[r] && (cnt_r[r] != {CNT_W{1'b1}})) begin
                    cnt_r[r] <= cnt_r[r] + CNT_W'(1);
                end
            end
        end
    end

    // Host read port.
    always_comb begin
        data = {CNT_W{1'b0}};
        if (int'(idx) < RULES) begin
            data = cnt_r[idx];
        end else begin
            data = {CNT_W{1'b0}};
        end
    end

endmodule

// File: rtl/sro_sweep_ctrl.sv
// Seed-sweep sequencer around the SRO datapath: fetch seed, reset/load/start
// the datapath, wait for the run to end, accumulate results per rule.
// Optional: define SRO_SWEEP_SS_ROUND_EN for steady-state round min/max outputs.
module sro_sweep_ctrl
    import sro_pkg::*;
#(
    parameter int RULES       = 32,
    parameter int LOG_RULES   = 5,
    parameter int NUM_SEEDS   = 1024,
    parameter int SEED_W      = 64,
    parameter int ROUND_W     = 10,
    parameter int ROUND_LIMIT = ROUND_LIMIT_DEFAULT,
    localparam int ADDR_W     = (NUM_SEEDS > 1) ? $clog2(NUM_SEEDS) : 1,
    localparam int CNT_W      = cnt_width(NUM_SEEDS)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 go,
    input  logic                 early_stop,
    input  logic [LOG_RULES-1:0] inhib_sel,
    output logic                 busy,
    output logic                 done,
    output logic [ADDR_W-1:0]    seed_addr,
    input  logic [SEED_W-1:0]    seed_data,
    output logic                 dp_rst_n,
    output logic                 dp_ld_inhibitor,
    output logic                 dp_start,
    output logic [LOG_RULES-1:0] dp_sel_inhibitor,
    output logic [SEED_W-1:0]    dp_seed,
    input  logic                 dp_steady_state,
    input  logic [RULES-1:0]     dp_network_state,
    input  logic [ROUND_W-1:0]   dp_round_number,
    input  logic [LOG_RULES-1:0] acc_idx,
    output logic [CNT_W-1:0]     acc_data,
    output logic [CNT_W-1:0]     ss_count
`ifdef SRO_SWEEP_SS_ROUND_EN
    ,
    output logic [ROUND_W-1:0]   ss_round_min,
    output logic [ROUND_W-1:0]   ss_round_max
`endif
);

    sro_state_e state_r, state_s;
    logic       dprst_ph_r;

    logic [ADDR_W-1:0]    idx_r;
    logic                 es_r;
    logic                 ss_cause_r;
    logic [RULES-1:0]     net_r;
    logic [LOG_RULES-1:0] sel_r;
    logic [SEED_W-1:0]    seed_r;
    logic [CNT_W-1:0]     ss_cnt_r;
    logic                 busy_r, done_r, rst_n_r, ld_r, start_r;

    logic go_acc_s, ss_hit_s, term_s, last_s, accum_s, run_end_s;

    // Decode of sweep-level events used by both FSM and datapath registers.
    always_comb begin
        go_acc_s  = (state_r == ST_IDLE) && go;
        ss_hit_s  = es_r && dp_steady_state;
        term_s    = ss_hit_s || (dp_round_number >= ROUND_W'(ROUND_LIMIT));
        last_s    = (idx_r == ADDR_W'(NUM_SEEDS - 1));
        accum_s   = (state_r == ST_ACCUM);
        run_end_s = (state_r == ST_RUN) && term_s;
    end

    // Next-state logic.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (go) state_s = ST_FETCH;
                else    state_s = ST_IDLE;
            end
            ST_FETCH: state_s = ST_LATCH;
            ST_LATCH: state_s = ST_DPRST;
            ST_DPRST: begin
                if (dprst_ph_r) state_s = ST_LDINH;
                else            state_s = ST_DPRST;
            end
            ST_LDINH: state_s = ST_GAP;
            ST_GAP:   state_s = ST_START;
            ST_START: state_s = ST_RUN;
            ST_RUN: begin
                if (term_s) state_s = ST_ACCUM;
                else        state_s = ST_RUN;
            end
            ST_ACCUM: begin
                if (last_s) state_s = ST_DONE;
                else        state_s = ST_FETCH;
            end
            ST_DONE:  state_s = ST_IDLE;
            default:  state_s = ST_IDLE;
        endcase
    end

    // State register; the phase bit stretches DPRST to two cycles.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            dprst_ph_r <= 1'b0;
        end else begin
            state_r    <= state_s;
            dprst_ph_r <= (state_r == ST_DPRST) ? ~dprst_ph_r : 1'b0;
        end
    end

    // Control outputs registered from the next state so they align with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
            rst_n_r <= 1'b0;
            ld_r    <= 1'b0;
            start_r <= 1'b0;
        end else begin
            busy_r  <= (state_s != ST_IDLE);
            done_r  <= (state_s == ST_DONE);
            rst_n_r <= !((state_s == ST_IDLE) || (state_s == ST_DPRST));
            ld_r    <= (state_s == ST_LDINH);
            start_r <= (state_s == ST_START);
        end
    end

    // Sweep context: seed index, latched config, seed, run result, ss count.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_r      <= {ADDR_W{1'b0}};
            es_r       <= 1'b0;
            sel_r      <= {LOG_RULES{1'b1}};
            seed_r     <= {SEED_W{1'b0}};
            net_r      <= {RULES{1'b0}};
            ss_cause_r <= 1'b0;
            ss_cnt_r   <= {CNT_W{1'b0}};
        end else begin
            if (go_acc_s) begin
                idx_r    <= {ADDR_W{1'b0}};
                es_r     <= early_stop;
                sel_r    <= inhib_sel;
                ss_cnt_r <= {CNT_W{1'b0}};
            end else if (accum_s) begin
                if (ss_cause_r && (ss_cnt_r != {CNT_W{1'b1}})) begin
                    ss_cnt_r <= ss_cnt_r + CNT_W'(1);
                end
                if (!last_s) begin
                    idx_r <= idx_r + ADDR_W'(1);
                end
            end
            if (state_r == ST_LATCH) begin
                seed_r <= seed_data;
            end
            // A simultaneous limit hit still counts as a steady-state end.
            if (run_end_s) begin
                net_r      <= dp_network_state;
                ss_cause_r <= ss_hit_s;
            end
        end
    end

`ifdef SRO_SWEEP_SS_ROUND_EN
    logic [ROUND_W-1:0] end_round_r;
    logic [ROUND_W-1:0] rmin_r, rmax_r;

    // Round statistics over steady-state terminations.
    always_ff @(posedge clk) begin
        if (rst) begin
            end_round_r <= {ROUND_W{1'b0}};
            rmin_r      <= {ROUND_W{1'b1}};
            rmax_r      <= {ROUND_W{1'b0}};
        end else if (go_acc_s) begin
            rmin_r <= {ROUND_W{1'b1}};
            rmax_r <= {ROUND_W{1'b0}};
        end else begin
            if (run_end_s) begin
                end_round_r <= dp_round_number;
            end
            if (accum_s && ss_cause_r) begin
                if (end_round_r < rmin_r) rmin_r <= end_round_r;
                if (end_round_r > rmax_r) rmax_r <= end_round_r;
            end
        end
    end

    assign ss_round_min = rmin_r;
    assign ss_round_max = rmax_r;
`endif

    sro_rule_accum #(
        .RULES     (RULES),
        .LOG_RULES (LOG_RULES),
        .CNT_W     (CNT_W)
    ) u_accum (
        .clk  (clk),
        .rst  (rst),
        .clr  (go_acc_s),
        .en   (accum_s),
        .bits (net_r),
        .idx  (acc_idx),
        .data (acc_data)
    );

    assign busy             = busy_r;
    assign done             = done_r;
    assign seed_addr        = idx_r;
    assign dp_rst_n         = rst_n_r;
    assign dp_ld_inhibitor  = ld_r;
    assign dp_start         = start_r;
    assign dp_sel_inhibitor = sel_r;
    assign dp_seed          = seed_r;
    assign ss_count         = ss_cnt_r;

endmodule

// File: tb/tb_sro_sweep_ctrl.sv
// Scoreboard bench for sro_sweep_ctrl with a behavioural seed RAM and
// datapath model; randomized sweeps plus directed reset / tie cases.
`timescale 1ns/1ps
module tb_sro_sweep_ctrl;

    localparam int RULES = 32, LOG_RULES = 5, NS = 4, SEED_W = 64;
    localparam int ROUND_W = 10, LIMIT = 10, CNT_W = 3, ADDR_W = 2;
    localparam int NEVER = 1023;

    logic clk = 1'b0;
    logic rst, go, early_stop;
    logic [LOG_RULES-1:0] inhib_sel;
    logic busy, done, dp_rst_n, dp_ld_inhibitor, dp_start, dp_steady_state;
    logic [ADDR_W-1:0]    seed_addr;
    logic [SEED_W-1:0]    seed_data, dp_seed;
    logic [LOG_RULES-1:0] dp_sel_inhibitor;
    logic [RULES-1:0]     dp_network_state;
    logic [ROUND_W-1:0]   dp_round_number;
    logic [LOG_RULES-1:0] acc_idx = 5'd0;
    logic [CNT_W-1:0]     acc_data, ss_count;
`ifdef SRO_SWEEP_SS_ROUND_EN
    logic [ROUND_W-1:0]   ss_round_min, ss_round_max;
`endif

    sro_sweep_ctrl #(
        .RULES(RULES), .LOG_RULES(LOG_RULES), .NUM_SEEDS(NS), .SEED_W(SEED_W),
        .ROUND_W(ROUND_W), .ROUND_LIMIT(LIMIT)
    ) dut (
        .clk(clk), .rst(rst), .go(go), .early_stop(early_stop), .inhib_sel(inhib_sel),
        .busy(busy), .done(done), .seed_addr(seed_addr), .seed_data(seed_data),
        .dp_rst_n(dp_rst_n), .dp_ld_inhibitor(dp_ld_inhibitor), .dp_start(dp_start),
        .dp_sel_inhibitor(dp_sel_inhibitor), .dp_seed(dp_seed),
        .dp_steady_state(dp_steady_state), .dp_network_state(dp_network_state),
        .dp_round_number(dp_round_number), .acc_idx(acc_idx), .acc_data(acc_data),
        .ss_count(ss_count)
`ifdef SRO_SWEEP_SS_ROUND_EN
        , .ss_round_min(ss_round_min), .ss_round_max(ss_round_max)
`endif
    );

    always #50 clk = ~clk;

    int cmp_cnt = 0;
    int err_cnt = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        cmp_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: actual=%0h required=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // ---------------- environment: seed RAM + datapath model ----------------
    logic [SEED_W-1:0] ram [NS];
    logic [31:0]       ns_base [NS];
    int                st_rnd [NS];
    bit                mix_on = 1'b0;
    logic              running = 1'b0;
    logic [ROUND_W-1:0] round = 10'd0;
    int                cur = 0;
    int                run_no = 0;

    always @(posedge clk) begin
        seed_data <= ram[seed_addr];
        if (!dp_rst_n) begin
            running <= 1'b0;
            round   <= 10'd0;
        end else if (dp_start) begin
            running <= 1'b1;
            round   <= 10'd0;
            cur     <= run_no;
        end else if (running) begin
            round <= round + 10'd1;
        end
        if (!busy) run_no <= 0;
        else if (dp_start) run_no <= run_no + 1;
    end

    assign dp_round_number  = round;
    assign dp_steady_state  = running && (int'(round) >= st_rnd[cur]);
    assign dp_network_state = ns_base[cur] ^ (mix_on ? 32'(round) * 32'h0001_0001 : 32'h0);

    // ---------------- scoreboard ----------------
    typedef struct packed {
        logic [31:0]        idx;
        logic [SEED_W-1:0]  seed;
        logic [LOG_RULES-1:0] sel;
    } run_exp_t;
    typedef struct packed {
        logic [RULES-1:0][7:0] acc;
        logic [7:0]  ss;
        logic [9:0]  rmin;
        logic [9:0]  rmax;
    } done_exp_t;

    run_exp_t  run_q [$];
    done_exp_t done_q [$];
    int exp_dones = 0;
    int done_cnt  = 0;

    // Reference: each run ends at its steady round (if early stop and within the
    // limit, ties included) or at the limit; count rules high in the end state.
    task automatic push_expect(input bit es, input logic [LOG_RULES-1:0] sel);
        done_exp_t d;
        int cnt [RULES];
        int ss = 0, rmin = NEVER, rmax = 0;
        for (int r = 0; r < RULES; r++) cnt[r] = 0;
        for (int s = 0; s < NS; s++) begin
            bit sse = es && (st_rnd[s] <= LIMIT);
            int er = sse ? st_rnd[s] : LIMIT;
            logic [31:0] fin = ns_base[s] ^ (mix_on ? 32'(er) * 32'h0001_0001 : 32'h0);
            for (int r = 0; r < RULES; r++) if (fin[r]) cnt[r]++;
            if (sse) begin
                ss++;
                if (er < rmin) rmin = er;
                if (er > rmax) rmax = er;
            end
            run_q.push_back('{32'(s), ram[s], sel});
        end
        for (int r = 0; r < RULES; r++) d.acc[r] = 8'((cnt[r] > 7) ? 7 : cnt[r]);
        d.ss   = 8'((ss > 7) ? 7 : ss);
        d.rmin = 10'(rmin);
        d.rmax = 10'(rmax);
        done_q.push_back(d);
    endtask

    // Monitor: checks each run start and each sweep end against the queues.
    int last_low = 0, cur_low = 0, since_ld = 99;
    bit after_done = 1'b0;
    run_exp_t  re;
    done_exp_t de;
    initial begin
        forever begin
            @(negedge clk);
            if (after_done) begin
                chk("busy_after_done", 64'(busy), 64'd0);
                chk("done_one_cycle", 64'(done), 64'd0);
                after_done = 1'b0;
            end
            if (!dp_rst_n) cur_low++;
            else if (cur_low != 0) begin
                last_low = cur_low;
                cur_low  = 0;
            end
            if (dp_ld_inhibitor) since_ld = 0;
            else if (since_ld < 99) since_ld++;
            if (dp_start) begin
                if (run_q.size() == 0) begin
                    chk("unexpected_dp_start", 64'(dp_start), 64'd0);
                end else begin
                    re = run_q.pop_front();
                    chk("seed_addr", 64'(seed_addr), 64'(re.idx));
                    chk("dp_seed", dp_seed, re.seed);
                    chk("dp_sel_inhibitor", 64'(dp_sel_inhibitor), 64'(re.sel));
                    chk("dp_rst_n_low_len", 64'(last_low), 64'd2);
                    chk("ld_to_start", 64'(since_ld), 64'd2);
                end
            end
            if (done) begin
                done_cnt++;
                if (done_q.size() == 0) begin
                    chk("unexpected_done", 64'(done), 64'd0);
                end else begin
                    de = done_q.pop_front();
                    chk("ss_count", 64'(ss_count), 64'(de.ss));
`ifdef SRO_SWEEP_SS_ROUND_EN
                    chk("ss_round_min", 64'(ss_round_min), 64'(de.rmin));
                    chk("ss_round_max", 64'(ss_round_max), 64'(de.rmax));
`endif
                    for (int i = 0; i < RULES; i++) begin
                        acc_idx = 5'(i);
                        #1;
                        chk($sformatf("acc_data[%0d]", i), 64'(acc_data), 64'(de.acc[i]));
                    end
                end
                after_done = 1'b1;
            end
        end
    end

    // ---------------- stimulus ----------------
    task automatic randomize_cfg();
        for (int s = 0; s < NS; s++) begin
            ram[s]     = {$urandom, $urandom};
            ns_base[s] = $urandom;
            st_rnd[s]  = ($urandom_range(0, 3) == 0) ? NEVER : int'($urandom_range(1, 12));
        end
        mix_on = 1'($urandom_range(0, 1));
    endtask

    task automatic start_sweep(input bit es, input logic [LOG_RULES-1:0] sel);
        push_expect(es, sel);
        go = 1'b1;
        early_stop = es;
        inhib_sel = sel;
        @(negedge clk);
        go = 1'b0;
    endtask

    task automatic recover();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        run_q.delete();
        done_q.delete();
    endtask

    task automatic run_full(input bit es, input logic [LOG_RULES-1:0] sel, input bit noise);
        int cyc = 0;
        bit seen = 1'b0;
        start_sweep(es, sel);
        exp_dones++;
        while (!seen && cyc < 3000) begin
            @(negedge clk);
            cyc++;
            if (done) begin
                seen = 1'b1;
                go = 1'b0;
            end else if (noise) begin
                go = 1'($urandom_range(0, 1));
                early_stop = 1'($urandom_range(0, 1));
                inhib_sel = 5'($urandom);
            end
        end
        go = 1'b0;
        if (!seen) begin
            chk("done_timeout", 64'(seen), 64'd1);
            recover();
            exp_dones--;
        end
        repeat (4) @(negedge clk);
    endtask

    initial begin
        int starts, cyc;
        rst = 1'b1; go = 1'b0; early_stop = 1'b0; inhib_sel = 5'd0;
        for (int s = 0; s < NS; s++) begin
            ram[s] = 64'd0; ns_base[s] = 32'd0; st_rnd[s] = NEVER;
        end
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_done", 64'(done), 64'd0);
        chk("rst_dp_rst_n", 64'(dp_rst_n), 64'd0);
        chk("rst_dp_start", 64'(dp_start), 64'd0);
        chk("rst_dp_ld", 64'(dp_ld_inhibitor), 64'd0);
        chk("rst_seed_addr", 64'(seed_addr), 64'd0);
        chk("rst_dp_seed", dp_seed, 64'd0);
        chk("rst_sel", 64'(dp_sel_inhibitor), 64'h1F);
        chk("rst_ss_count", 64'(ss_count), 64'd0);
        chk("rst_acc", 64'(acc_data), 64'd0);
`ifdef SRO_SWEEP_SS_ROUND_EN
        chk("rst_rmin", 64'(ss_round_min), 64'h3FF);
        chk("rst_rmax", 64'(ss_round_max), 64'd0);
`endif
        rst = 1'b0;
        repeat (2) @(negedge clk);

        // Fixed 0xF1 end state, no early stop.
        randomize_cfg();
        mix_on = 1'b0;
        for (int s = 0; s < NS; s++) begin ns_base[s] = 32'h0000_00F1; st_rnd[s] = NEVER; end
        run_full(1'b0, 5'($urandom), 1'b0);

        // Steady at round 3 on seeds 1 and 3.
        randomize_cfg();
        st_rnd[0] = NEVER; st_rnd[1] = 3; st_rnd[2] = NEVER; st_rnd[3] = 3;
        run_full(1'b1, 5'($urandom), 1'b0);

        // Steady exactly at the limit, one beyond it, one early.
        randomize_cfg();
        st_rnd[0] = LIMIT; st_rnd[1] = NEVER; st_rnd[2] = 12; st_rnd[3] = 5;
        run_full(1'b1, 5'($urandom), 1'b0);

        // Abort during the run of seed 2.
        randomize_cfg();
        for (int s = 0; s < NS; s++) begin ns_base[s] = 32'hFFFF_FFFF; st_rnd[s] = NEVER; end
        mix_on = 1'b0;
        start_sweep(1'b0, 5'h0A);
        starts = 0; cyc = 0;
        while (starts < 3 && cyc < 500) begin
            @(negedge clk);
            cyc++;
            if (dp_start) starts++;
        end
        chk("reach_seed2_run", 64'(starts), 64'd3);
        repeat (3) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_dp_rst_n", 64'(dp_rst_n), 64'd0);
        chk("abort_seed_addr", 64'(seed_addr), 64'd0);
        chk("abort_sel", 64'(dp_sel_inhibitor), 64'h1F);
        chk("abort_ss_count", 64'(ss_count), 64'd0);
        chk("abort_acc", 64'(acc_data), 64'd0);
        rst = 1'b0;
        run_q.delete();
        done_q.delete();
        repeat (2) @(negedge clk);

        // Random sweeps, some with go/config noise while busy.
        randomize_cfg();
        run_full(1'b1, 5'($urandom), 1'b1);
        for (int k = 0; k < 5; k++) begin
            randomize_cfg();
            run_full(1'($urandom_range(0, 1)), 5'($urandom), 1'($urandom_range(0, 1)));
        end

        repeat (150) @(negedge clk);
        chk("final_busy", 64'(busy), 64'd0);
        chk("done_pulses", 64'(done_cnt), 64'(exp_dones));
        chk("run_q_drained", 64'(run_q.size()), 64'd0);
        chk("done_q_drained", 64'(done_q.size()), 64'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/sro_sweep_ctrl.md
Name: sro_sweep_ctrl

Overview:
Hardware sequencer that replaces the bench-driven seed loop around the SRO datapath. For each of NUM_SEEDS seeds it reads the seed from a seed memory, then resets, inhibitor-loads and starts the datapath. It waits for the round limit, or for steady state if early stop is enabled, and then adds the final network_state into per-rule "ended-high" counters. Sits between the seed RAM and the datapath; the host reads results after done.

Parameters:
RULES, 32, number of network rules (network_state width)
LOG_RULES, 5, width of inhibitor select
NUM_SEEDS, 1024, seeds per sweep (seed RAM depth)
SEED_W, 64, seed width
ROUND_W, 10, datapath round_number width
ROUND_LIMIT, 1000, rounds per run

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
go  in  1  start sweep (accepted only in IDLE)
early_stop  in  1  latched on go; end run on steady_state
inhib_sel  in  LOG_RULES  latched on go; drives dp_sel_inhibitor for the whole sweep
busy  out  1  high from the cycle after go acceptance until DONE
done  out  1  one-cycle pulse at sweep end
seed_addr  out  clog2(NUM_SEEDS)  seed RAM address
seed_data  in  SEED_W  seed RAM data, valid 1 cycle after seed_addr
dp_rst_n  out  1  datapath reset, active-low
dp_ld_inhibitor  out  1  datapath inhibitor load strobe
dp_start  out  1  datapath start strobe
dp_sel_inhibitor  out  LOG_RULES  inhibitor select
dp_seed  out  SEED_W  registered seed, stable for the whole run
dp_steady_state  in  1  datapath steady flag
dp_network_state  in  RULES  datapath state
dp_round_number  in  ROUND_W  datapath round counter
acc_idx  in  LOG_RULES  result read index
acc_data  out  clog2(NUM_SEEDS+1)  count of seeds where rule acc_idx ended at 1 (combinational read)
ss_count  out  clog2(NUM_SEEDS+1)  runs that ended by steady state

Behaviour:
- Reset: FSM=IDLE; busy=0, done=0, dp_rst_n=0, dp_start=0, dp_ld_inhibitor=0, seed_addr=0, dp_seed=0, dp_sel_inhibitor=all-ones, all counters=0.
- Reset mid-sweep aborts to IDLE with the reset values above; there is no partial-result retention.
- FSM states: IDLE -> FETCH -> LATCH -> DPRST (2 cycles, dp_rst_n=0) -> LDINH (1 cycle, dp_ld_inhibitor=1) -> GAP (1 cycle) -> START (1 cycle, dp_start=1) -> RUN -> ACCUM -> FETCH (next seed) or DONE -> IDLE.
- IDLE: go=1 clears all counters and seed index, latches early_stop and inhib_sel, and moves to FETCH. go in any other state is ignored.
- FETCH drives seed_addr=index. LATCH captures seed_data into dp_seed.
- dp_rst_n is 0 only in DPRST and IDLE; 1 otherwise.
- RUN terminates in the first cycle where dp_round_number >= ROUND_LIMIT, or where (early_stop && dp_steady_state). In that cycle dp_network_state and the termination cause are registered. If both conditions are true in the same cycle, the run counts as a steady-state end.
- ACCUM: every rule counter r increments if registered bit r = 1. ss_count increments if the cause was steady state. Counters saturate at all-ones and never wrap.
- After ACCUM, if index == NUM_SEEDS-1 go to DONE, else index+1 and go to FETCH. Index never wraps within a sweep.
- DONE: done=1 for one cycle, busy=0 next cycle; counters hold until the next accepted go.
- Per-seed overhead outside RUN: 8 cycles.

Optional Feature:
SRO_SWEEP_SS_ROUND_EN
- Defined: adds outputs ss_round_min and ss_round_max (each ROUND_W bits), holding the min and max dp_round_number at steady-state terminations. Both reset and clear on go: min to all-ones, max to 0. They update in ACCUM.
- Undefined: ports and logic are absent.

Decomposition:
- Package sro_pkg: the FSM state enum, the count-width function/localparam, and the ROUND_LIMIT default.
- One sub-module: sro_rule_accum. It holds the RULES saturating counters with clear/enable and the indexed read mux.

Test Plan:
- NUM_SEEDS=4, ROUND_LIMIT=10, early_stop=0, datapath model holds network_state=32'h0000_00F1 at round 10 for every seed -> done after 4 runs; acc_data is 4 for idx 0, 4, 5, 6, 7 and 0 for all others; ss_count=0.
- Per-seed sequencing -> seed_addr steps 0..3; dp_seed equals RAM word; dp_rst_n low exactly 2 cycles; ld_inhibitor precedes dp_start by 2 cycles; dp_sel_inhibitor equals inhib_sel.
- early_stop=1, model asserts steady at round 3 on seeds 1 and 3 -> ss_count=2; those runs end at round 3. With SRO_SWEEP_SS_ROUND_EN: min=max=3.
- steady and round>=ROUND_LIMIT in the same cycle -> counted as steady (ss_count+1).
- rst asserted during RUN of seed 2 -> next cycle FSM=IDLE, busy=0, counters=0, dp_rst_n=0. A following go restarts from seed 0.
- go pulsed while busy -> ignored; sweep completes with unchanged counts and exactly one done pulse.
